// File: rtl/tq_pkg.sv
// Shared constants, quantizer tables and helpers for the forward transform/quant pipeline.
package tq_pkg;

  localparam int RES_W  = 9;
  localparam int LVL_W  = 15;
  localparam int QP_MAX = 51;
  localparam int ROW_W  = 12;
  localparam int COL_W  = 15;
  localparam int MF_W   = 14;
  localparam int PROD_W = 28;

  typedef enum logic [1:0] {
    PC_EVEN  = 2'd0,
    PC_ODD   = 2'd1,
    PC_MIXED = 2'd2
  } pos_class_e;

  // Rows are indexed by pos_class_e, columns by qp % 6.
  localparam logic [MF_W-1:0] MF_TAB [3][6] = '{
    '{14'd13107, 14'd11916, 14'd10082, 14'd9362, 14'd8192, 14'd7282},
    '{14'd5243,  14'd4660,  14'd4194,  14'd3647, 14'd3355, 14'd2893},
    '{14'd8066,  14'd7490,  14'd6554,  14'd5825, 14'd5243, 14'd4559}
  };

  // floor(2^(15+d)/3) and floor(2^(15+d)/6) for d = qp/6 = 0..8.
  localparam logic [PROD_W-1:0] F_INTRA [9] = '{
    28'd10922, 28'd21845, 28'd43690, 28'd87381, 28'd174762,
    28'd349525, 28'd699050, 28'd1398101, 28'd2796202
  };
  localparam logic [PROD_W-1:0] F_INTER [9] = '{
    28'd5461, 28'd10922, 28'd21845, 28'd43690, 28'd87381,
    28'd174762, 28'd349525, 28'd699050, 28'd1398101
  };

  typedef struct packed {
    logic signed [COL_W-1:0] y0;
    logic signed [COL_W-1:0] y1;
    logic signed [COL_W-1:0] y2;
    logic signed [COL_W-1:0] y3;
  } bf4_t;

  function automatic pos_class_e pos_class(input int r, input int c);
    if (r[0] == c[0]) return r[0] ? PC_ODD : PC_EVEN;
    return PC_MIXED;
  endfunction

  function automatic logic [MF_W-1:0] mf_lookup(input int cls, input logic [2:0] md);
    logic [2:0] m;
    m = (md > 3'd5) ? 3'd0 : md;
    return MF_TAB[cls][m];
  endfunction

  function automatic logic [PROD_W-1:0] f_round(input logic [3:0] d, input logic intra);
    logic [3:0] di;
    di = (d > 4'd8) ? 4'd8 : d;
    return intra ? F_INTRA[di] : F_INTER[di];
  endfunction

  function automatic logic [3:0] tq_div6(input logic [5:0] qp);
    return 4'(qp / 6'd6);
  endfunction

  function automatic logic [2:0] tq_mod6(input logic [5:0] qp);
    return 3'(qp % 6'd6);
  endfunction

  function automatic bf4_t butterfly(input logic signed [COL_W-1:0] x0, x1, x2, x3);
    bf4_t b;
    b.y0 = x0 + x1 + x2 + x3;
    b.y1 = (x0 <<< 1) + x1 - x2 - (x3 <<< 1);
    b.y2 = x0 - x1 - x2 + x3;
    b.y3 = x0 - (x1 <<< 1) + (x2 <<< 1) - x3;
    return b;
  endfunction

endpackage

// File: rtl/tq_quant_coef.sv
// Scalar quantizer for one transform coefficient: sign-magnitude multiply, round, shift.
module tq_quant_coef
  import tq_pkg::*;
(
  input  logic [COL_W-1:0]  w_i,
  input  logic [MF_W-1:0]   mf_i,
  input  logic [PROD_W-1:0] f_i,
  input  logic [4:0]        qbits_i,
  output logic [LVL_W-1:0]  lvl_o
);

  logic              neg;
  logic [COL_W-1:0]  mag;
  logic [PROD_W-1:0] sum;
  logic [LVL_W-1:0]  lvl_mag;

  always_comb begin
    neg     = w_i[COL_W-1];
    mag     = neg ? (~w_i + COL_W'(1)) : w_i;
    sum     = (PROD_W'(mag) * PROD_W'(mf_i)) + f_i;
    lvl_mag = LVL_W'(sum >> qbits_i);
    // A zero magnitude negates to zero, so no negative zero escapes.
    lvl_o   = neg ? (~lvl_mag + LVL_W'(1)) : lvl_mag;
  end

endmodule

// File: rtl/tq_dct_quant_pipe.sv
// 4x4 forward integer transform + quantizer: input capture, row pass, column pass, quant.
// A single enable stalls every stage together whenever the output is held.
module tq_dct_quant_pipe
  import tq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [16*RES_W-1:0]  res_i,
  input  logic [5:0]           qp_i,
  input  logic                 intra_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [16*LVL_W-1:0]  lvl_o,
  output logic [4:0]           nz_cnt_o
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // ready depends only on the output stage and out_ready_i, never on in_valid_i.
  logic en;

  logic                v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
  logic [16*RES_W-1:0] res0_q, res0_d;
  logic [5:0]          qp0_q, qp0_d, qp1_q, qp1_d;
  logic                intra0_q, intra0_d, intra1_q, intra1_d, intra2_q, intra2_d;
  logic [16*ROW_W-1:0] row_q, row_d, row_w;
  logic [16*COL_W-1:0] col_q, col_d, col_w;
  logic [3:0]          qpdiv_q, qpdiv_d;
  logic [2:0]          qpmod_q, qpmod_d;
  logic [16*LVL_W-1:0] lvl_q, lvl_d, lvl_w;
  logic [4:0]          nz_q, nz_d, nz_w;
  logic [4:0]          qbits_w;
  logic [PROD_W-1:0]   f_w;

  assign en          = ~out_valid_q | out_ready_i;
  assign in_ready_o  = en;
  assign out_valid_o = out_valid_q;
  assign lvl_o       = lvl_q;
  assign nz_cnt_o    = nz_q;

  always_comb begin
    bf4_t bf;
    bf    = '0;
    row_w = '0;
    for (int r = 0; r < 4; r++) begin
      bf = butterfly(COL_W'($signed(res0_q[(4*r+0)*RES_W +: RES_W])),
                     COL_W'($signed(res0_q[(4*r+1)*RES_W +: RES_W])),
                     COL_W'($signed(res0_q[(4*r+2)*RES_W +: RES_W])),
                     COL_W'($signed(res0_q[(4*r+3)*RES_W +: RES_W])));
      row_w[(4*r+0)*ROW_W +: ROW_W] = bf.y0[ROW_W-1:0];
      row_w[(4*r+1)*ROW_W +: ROW_W] = bf.y1[ROW_W-1:0];
      row_w[(4*r+2)*ROW_W +: ROW_W] = bf.y2[ROW_W-1:0];
      row_w[(4*r+3)*ROW_W +: ROW_W] = bf.y3[ROW_W-1:0];
    end
  end

  always_comb begin
    bf4_t bf;
    bf    = '0;
    col_w = '0;
    for (int c = 0; c < 4; c++) begin
      bf = butterfly(COL_W'($signed(row_q[(0+c)*ROW_W +: ROW_W])),
                     COL_W'($signed(row_q[(4+c)*ROW_W +: ROW_W])),
                     COL_W'($signed(row_q[(8+c)*ROW_W +: ROW_W])),
                     COL_W'($signed(row_q[(12+c)*ROW_W +: ROW_W])));
      col_w[(0+c)*COL_W +: COL_W]  = bf.y0;
      col_w[(4+c)*COL_W +: COL_W]  = bf.y1;
      col_w[(8+c)*COL_W +: COL_W]  = bf.y2;
      col_w[(12+c)*COL_W +: COL_W] = bf.y3;
    end
  end

  assign qbits_w = 5'd15 + {1'b0, qpdiv_q};
  assign f_w     = f_round(qpdiv_q, intra2_q);

  for (genvar g = 0; g < 16; g++) begin : g_quant
    localparam pos_class_e CLS = pos_class(g / 4, g % 4);
    logic [MF_W-1:0] mf;
    assign mf = mf_lookup(int'(CLS), qpmod_q);
    tq_quant_coef u_coef (
      .w_i     (col_q[g*COL_W +: COL_W]),
      .mf_i    (mf),
      .f_i     (f_w),
      .qbits_i (qbits_w),
      .lvl_o   (lvl_w[g*LVL_W +: LVL_W])
    );
  end

  always_comb begin
    nz_w = '0;
    for (int g = 0; g < 16; g++) begin
      if (lvl_w[g*LVL_W +: LVL_W] != '0) nz_w = nz_w + 5'd1;
    end
  end

  always_comb begin
    v0_d        = v0_q;
    res0_d      = res0_q;
    qp0_d       = qp0_q;
    intra0_d    = intra0_q;
    v1_d        = v1_q;
    row_d       = row_q;
    qp1_d       = qp1_q;
    intra1_d    = intra1_q;
    v2_d        = v2_q;
    col_d       = col_q;
    qpdiv_d     = qpdiv_q;
    qpmod_d     = qpmod_q;
    intra2_d    = intra2_q;
    out_valid_d = out_valid_q;
    lvl_d       = lvl_q;
    nz_d        = nz_q;
    if (en) begin
      v0_d        = in_valid_i;
      res0_d      = res_i;
      qp0_d       = qp_i;
      intra0_d    = intra_i;
      v1_d        = v0_q;
      row_d       = row_w;
      qp1_d       = (qp0_q > 6'(QP_MAX)) ? 6'(QP_MAX) : qp0_q;
      intra1_d    = intra0_q;
      v2_d        = v1_q;
      col_d       = col_w;
      qpdiv_d     = tq_div6(qp1_q);
      qpmod_d     = tq_mod6(qp1_q);
      intra2_d    = intra1_q;
      out_valid_d = v2_q;
      lvl_d       = lvl_w;
      nz_d        = nz_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q        <= 1'b0;
      res0_q      <= '0;
      qp0_q       <= '0;
      intra0_q    <= 1'b0;
      v1_q        <= 1'b0;
      row_q       <= '0;
      qp1_q       <= '0;
      intra1_q    <= 1'b0;
      v2_q        <= 1'b0;
      col_q       <= '0;
      qpdiv_q     <= '0;
      qpmod_q     <= '0;
      intra2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      lvl_q       <= '0;
      nz_q        <= '0;
    end else begin
      v0_q        <= v0_d;
      res0_q      <= res0_d;
      qp0_q       <= qp0_d;
      intra0_q    <= intra0_d;
      v1_q        <= v1_d;
      row_q       <= row_d;
      qp1_q       <= qp1_d;
      intra1_q    <= intra1_d;
      v2_q        <= v2_d;
      col_q       <= col_d;
      qpdiv_q     <= qpdiv_d;
      qpmod_q     <= qpmod_d;
      intra2_q    <= intra2_d;
      out_valid_q <= out_valid_d;
      lvl_q       <= lvl_d;
      nz_q        <= nz_d;
    end
  end

endmodule

// File: tb/tb_tq_dct_quant_pipe.sv
// Directed bench for tq_dct_quant_pipe: hand-computed vectors plus a matrix-form reference.
module tb_tq_dct_quant_pipe;

  localparam int RW = 9;
  localparam int LW = 15;
  localparam int LV = 16 * LW;

  localparam int CM [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
  localparam int MFT [3][6] = '{
    '{13107, 11916, 10082, 9362, 8192, 7282},
    '{5243, 4660, 4194, 3647, 3355, 2893},
    '{8066, 7490, 6554, 5825, 5243, 4559}};

  logic            clk, rst;
  logic            in_valid_i, in_ready_o, intra_i, out_valid_o, out_ready_i;
  logic [16*RW-1:0] res_i;
  logic [5:0]      qp_i;
  logic [LV-1:0]   lvl_o;
  logic [4:0]      nz_cnt_o;

  tq_dct_quant_pipe dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .res_i(res_i), .qp_i(qp_i), .intra_i(intra_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .lvl_o(lvl_o), .nz_cnt_o(nz_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [LV-1:0] exp_lvl_q[$];
  logic [4:0]    exp_nz_q[$];
  int            checks = 0;
  int            errors = 0;
  int            n_pop = 0;
  bit            auto_exp = 1'b0;
  logic [LV-1:0] last_lvl;
  logic [4:0]    last_nz;
  int            hl [16];

  task automatic chk(input string tag, input logic [LV-1:0] got, input logic [LV-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic void model(input logic [16*RW-1:0] res, input logic [5:0] qp,
                                input logic intra, output logic [LV-1:0] lvl, output logic [4:0] nz);
    int x [4][4];
    int w;
    int qpc, qb, f, mf, a, l, cls;
    lvl = '0;
    nz  = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        x[r][c] = int'($signed(res[(4*r+c)*RW +: RW]));
    qpc = (qp > 6'd51) ? 51 : int'(qp);
    qb  = 15 + qpc / 6;
    f   = (1 << qb) / (intra ? 3 : 6);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        w = 0;
        for (int k = 0; k < 4; k++)
          for (int m = 0; m < 4; m++)
            w += CM[i][k] * x[k][m] * CM[j][m];
        cls = ((i % 2) == (j % 2)) ? (i % 2) : 2;
        mf  = MFT[cls][qpc % 6];
        a   = (w < 0) ? -w : w;
        l   = (a * mf + f) >> qb;
        if (w < 0) l = -l;
        lvl[(4*i+j)*LW +: LW] = LW'(l);
        if (l != 0) nz = nz + 5'd1;
      end
    end
  endfunction

  function automatic logic [LV-1:0] pack_hl();
    logic [LV-1:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i*LW +: LW] = LW'(hl[i]);
    return v;
  endfunction

  function automatic logic [16*RW-1:0] rand_blk();
    logic [16*RW-1:0] b;
    int v;
    for (int i = 0; i < 16; i++) begin
      v = int'($urandom_range(510, 0)) - 255;
      b[i*RW +: RW] = RW'(v);
    end
    return b;
  endfunction

  // One clock: settle, record handshakes, check any popped output, advance to the next negedge.
  task automatic cycle(output bit acc);
    logic [LV-1:0] ml, el;
    logic [4:0]    mn, en;
    #1;
    acc = in_valid_i && in_ready_o;
    if (acc && auto_exp) begin
      model(res_i, qp_i, intra_i, ml, mn);
      exp_lvl_q.push_back(ml);
      exp_nz_q.push_back(mn);
    end
    if (out_valid_o && out_ready_i) begin
      n_pop++;
      last_lvl = lvl_o;
      last_nz  = nz_cnt_o;
      if (exp_lvl_q.size() == 0) begin
        chk("unexpected_output", LV'(out_valid_o), '0);
      end else begin
        el = exp_lvl_q.pop_front();
        en = exp_nz_q.pop_front();
        chk("lvl", lvl_o, el);
        chk("nz_cnt", LV'(nz_cnt_o), LV'(en));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    bit a;
    cycle(a);
  endtask

  task automatic drain();
    in_valid_i = 1'b0;
    for (int i = 0; i < 20 && exp_lvl_q.size() > 0; i++) step();
    chk("drain_empty", LV'(exp_lvl_q.size()), '0);
  endtask

  initial begin
    logic [16*RW-1:0] blk4 [5];
    logic [5:0]       qp4 [5];
    logic             in4 [5];
    logic [16*RW-1:0] b;
    logic [LV-1:0]    held, lvl_a;
    logic [4:0]       held_nz, nz_a;
    int               k, stall_left;
    bit               acc;

    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    res_i = '0; qp_i = '0; intra_i = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", LV'(out_valid_o), '0);
    chk("rst_lvl", lvl_o, '0);
    chk("rst_nz", LV'(nz_cnt_o), '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", LV'(in_ready_o), LV'(1));

    // Test 1: zero block, latency of three edges after acceptance.
    auto_exp = 1'b0;
    res_i = '0; qp_i = 6'd28; intra_i = 1'b1; in_valid_i = 1'b1;
    exp_lvl_q.push_back('0); exp_nz_q.push_back(5'd0);
    step();
    in_valid_i = 1'b0;
    step(); chk("t1_lat1", LV'(out_valid_o), '0);
    step(); chk("t1_lat2", LV'(out_valid_o), '0);
    step(); chk("t1_lat3", LV'(out_valid_o), LV'(1));
    step(); chk("t1_after", LV'(out_valid_o), '0);

    // Test 2: flat +10 then -10 blocks, qp 28 intra.
    for (int i = 0; i < 16; i++) hl[i] = 0;
    hl[0] = 2;
    exp_lvl_q.push_back(pack_hl()); exp_nz_q.push_back(5'd1);
    hl[0] = -2;
    exp_lvl_q.push_back(pack_hl()); exp_nz_q.push_back(5'd1);
    for (int i = 0; i < 16; i++) res_i[i*RW +: RW] = 9'd10;
    in_valid_i = 1'b1;
    step();
    for (int i = 0; i < 16; i++) res_i[i*RW +: RW] = 9'h1F6;
    step();
    drain();

    // Test 3: single impulse at (0,0), qp 0 intra.
    hl = '{40, 49, 40, 24, 49, 64, 49, 32, 40, 49, 40, 24, 24, 32, 24, 16};
    exp_lvl_q.push_back(pack_hl()); exp_nz_q.push_back(5'd16);
    res_i = '0; res_i[RW-1:0] = 9'd100; qp_i = 6'd0; intra_i = 1'b1; in_valid_i = 1'b1;
    step();
    drain();

    // Test 4: five back-to-back blocks with a four-cycle output stall.
    auto_exp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      blk4[i] = rand_blk();
      qp4[i]  = 6'($urandom_range(51, 0));
      in4[i]  = 1'($urandom_range(1, 0));
    end
    k = 0; stall_left = 4; n_pop = 0; held = '0; held_nz = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (k >= 5 && exp_lvl_q.size() == 0) break;
      in_valid_i = (k < 5);
      if (k < 5) begin
        res_i = blk4[k]; qp_i = qp4[k]; intra_i = in4[k];
      end
      if (out_valid_o && stall_left > 0) begin
        out_ready_i = 1'b0;
        #1;
        if (stall_left < 4) begin
          chk("t4_hold_lvl", lvl_o, held);
          chk("t4_hold_nz", LV'(nz_cnt_o), LV'(held_nz));
        end
        chk("t4_in_ready_stall", LV'(in_ready_o), '0);
        held = lvl_o; held_nz = nz_cnt_o;
        stall_left--;
      end else begin
        out_ready_i = 1'b1;
      end
      cycle(acc);
      if (acc) k++;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    chk("t4_drained", LV'(exp_lvl_q.size()), '0);
    chk("t4_pop_count", LV'(n_pop), LV'(5));

    // Test 5: qp 63 must behave exactly like qp 51.
    b = rand_blk();
    res_i = b; qp_i = 6'd63; intra_i = 1'b0; in_valid_i = 1'b1;
    step();
    drain();
    lvl_a = last_lvl; nz_a = last_nz;
    res_i = b; qp_i = 6'd51; in_valid_i = 1'b1;
    step();
    drain();
    chk("t5_clamp_lvl", last_lvl, lvl_a);
    chk("t5_clamp_nz", LV'(last_nz), LV'(nz_a));

    // Test 6: async reset with two blocks in flight, then a clean block.
    res_i = rand_blk(); qp_i = 6'd20; intra_i = 1'b1; in_valid_i = 1'b1;
    step();
    res_i = rand_blk();
    step();
    in_valid_i = 1'b0;
    step();
    step();
    chk("t6_pre_valid", LV'(out_valid_o), LV'(1));
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_valid", LV'(out_valid_o), '0);
    chk("t6_rst_lvl", lvl_o, '0);
    chk("t6_rst_nz", LV'(nz_cnt_o), '0);
    exp_lvl_q.delete(); exp_nz_q.delete();
    rst = 1'b0;
    #1;
    res_i = rand_blk(); qp_i = 6'd33; intra_i = 1'b0; in_valid_i = 1'b1;
    n_pop = 0;
    step();
    in_valid_i = 1'b0;
    step(); chk("t6_lat1", LV'(out_valid_o), '0);
    step(); chk("t6_lat2", LV'(out_valid_o), '0);
    step(); chk("t6_lat3", LV'(out_valid_o), LV'(1));
    step(); chk("t6_alone", LV'(out_valid_o), '0);
    chk("t6_pop_count", LV'(n_pop), LV'(1));
    chk("t6_queue_empty", LV'(exp_lvl_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
